psr_flag_unit: RTL

- Processor status register stage directly downstream of the ALU.
- Captures the ALU condition outputs (carry, low, overflow, zero, negative) into a 5-bit PSR. Each instruction class updates only the flags it architecturally owns.
- Evaluates 4-bit Bcond/Jcond/Scond condition codes against the PSR with a registered result.
- Feeds the stored carry back to the ALU for ADDC/SUBC, and provides a one-deep shadow PSR for interrupt entry and return.

---
 rtl/psr_pkg.sv | 77 +++++++
 rtl/psr_cond_eval.sv | 42 ++++
 rtl/psr_flag_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/psr_pkg.sv
// Shared definitions for the processor status register stage: flag bit
// positions, condition-code encodings and the opcode nibbles that the ALU
// decoder uses as well.
package psr_pkg;

    localparam int FLAG_W = 5;

    // Flag bit positions inside the PSR
    localparam int C_BIT = 0;
    localparam int L_BIT = 1;
    localparam int F_BIT = 2;
    localparam int Z_BIT = 3;
    localparam int N_BIT = 4;

    // Condition-code encodings (Bcond/Jcond/Scond field)
    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_HI = 4'b0100;
    localparam logic [3:0] CC_LS = 4'b0101;
    localparam logic [3:0] CC_GT = 4'b0110;
    localparam logic [3:0] CC_LE = 4'b0111;
    localparam logic [3:0] CC_FS = 4'b1000;
    localparam logic [3:0] CC_FC = 4'b1001;
    localparam logic [3:0] CC_LO = 4'b1010;
    localparam logic [3:0] CC_HS = 4'b1011;
    localparam logic [3:0] CC_LT = 4'b1100;
    localparam logic [3:0] CC_GE = 4'b1101;
    localparam logic [3:0] CC_UC = 4'b1110;
    localparam logic [3:0] CC_NV = 4'b1111;

    // High nibble of the operation control word (opcode class)
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_ADDUI = 4'b0110;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;

    // Low nibble of the operation control word for RTYPE instructions
    localparam logic [3:0] FN_ADD  = 4'b0101;
    localparam logic [3:0] FN_ADDU = 4'b0110;
    localparam logic [3:0] FN_ADDC = 4'b0111;
    localparam logic [3:0] FN_SUB  = 4'b1001;
    localparam logic [3:0] FN_SUBC = 4'b1010;
    localparam logic [3:0] FN_CMP  = 4'b1011;

    // Write masks for the three flag-owning instruction groups
    localparam logic [FLAG_W-1:0] MASK_NONE = 5'b00000;
    localparam logic [FLAG_W-1:0] MASK_C    = 5'b00001;
    localparam logic [FLAG_W-1:0] MASK_CF   = 5'b00101;
    localparam logic [FLAG_W-1:0] MASK_LZN  = 5'b11010;

    // Which flags an instruction architecturally owns
    function automatic logic [FLAG_W-1:0] flag_mask(input logic [3:0] op_hi,
                                                    input logic [3:0] op_lo);
        logic [FLAG_W-1:0] m;
        m = MASK_NONE;
        if (op_hi == OP_RTYPE) begin
            case (op_lo)
                FN_ADDU, FN_ADDC, FN_SUBC: m = MASK_C;
                FN_ADD, FN_SUB:            m = MASK_CF;
                FN_CMP:                    m = MASK_LZN;
                default:                   m = MASK_NONE;
            endcase
        end else begin
            case (op_hi)
                OP_ADDUI:         m = MASK_C;
                OP_ADDI, OP_SUBI: m = MASK_CF;
                OP_CMPI:          m = MASK_LZN;
                default:          m = MASK_NONE;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/psr_cond_eval.sv
// Combinational condition-code evaluator: flags + 4-bit code -> taken.
module psr_cond_eval
    import psr_pkg::*;
(
    input  logic [FLAG_W-1:0] flags,
    input  logic [3:0]        code,
    output logic              taken
);

    logic c, l, f, z, n;

    assign c = flags[C_BIT];
    assign l = flags[L_BIT];
    assign f = flags[F_BIT];
    assign z = flags[Z_BIT];
    assign n = flags[N_BIT];

    // Decode the condition field against the selected flag set
    always_comb begin
        taken = 1'b0;
        case (code)
            CC_EQ: taken = z;
            CC_NE: taken = !z;
            CC_CS: taken = c;
            CC_CC: taken = !c;
            CC_HI: taken = l;
            CC_LS: taken = !l;
            CC_GT: taken = n;
            CC_LE: taken = !n;
            CC_FS: taken = f;
            CC_FC: taken = !f;
            CC_LO: taken = !l && !z;
            CC_HS: taken = l || z;
            CC_LT: taken = !n && !z;
            CC_GE: taken = n || z;
            CC_UC: taken = 1'b1;
            CC_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/psr_flag_unit.sv
// Processor status register stage after the ALU. Captures ALU flags under
// a per-instruction write mask, keeps a one-deep shadow copy for interrupt
// entry/return and evaluates branch condition codes with a registered result.
module psr_flag_unit
    import psr_pkg::*;
#(
    parameter int CTL_LEN = 8,
    parameter int BYPASS  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flag_en,
    input  logic [CTL_LEN-1:0] op_ctl,
    input  logic               carry_in,
    input  logic               low_in,
    input  logic               overflow_in,
    input  logic               zero_in,
    input  logic               negative_in,
    input  logic               cond_valid,
    input  logic [3:0]         cond_code,
    input  logic               psr_save,
    input  logic               psr_restore,
    output logic [FLAG_W-1:0]  psr,
    output logic               carry_fb,
    output logic               cond_done,
    output logic               cond_taken,
    output logic [FLAG_W-1:0]  shadow_psr
);

    logic [FLAG_W-1:0] psr_q, psr_d;
    logic [FLAG_W-1:0] shadow_q, shadow_d;
    logic              done_q, done_d;
    logic              taken_q, taken_d;

    logic [FLAG_W-1:0] flags_in;
    logic [FLAG_W-1:0] wr_mask;
    logic [FLAG_W-1:0] eval_flags;
    logic              taken_c;

    assign flags_in = {negative_in, zero_in, overflow_in, low_in, carry_in};

    // Only flags owned by the current instruction class may be written
    always_comb begin
        wr_mask = MASK_NONE;
        if (flag_en) begin
            wr_mask = flag_mask(op_ctl[7:4], op_ctl[3:0]);
        end
    end

    // Next PSR: restore wins over a flag write; shadow samples the old PSR,
    // so save+restore in one cycle swaps the two registers
    always_comb begin
        psr_d = (psr_q & ~wr_mask) | (flags_in & wr_mask);
        if (psr_restore) begin
            psr_d = shadow_q;
        end
        shadow_d = psr_save ? psr_q : shadow_q;
    end

    // Forwarding choice: evaluate against this cycle's update or the stored PSR
    assign eval_flags = (BYPASS != 0) ? psr_d : psr_q;

    psr_cond_eval u_cond_eval (
        .flags (eval_flags),
        .code  (cond_code),
        .taken (taken_c)
    );

    // Result register holds until the next evaluation request
    always_comb begin
        done_d  = cond_valid;
        taken_d = cond_valid ? taken_c : taken_q;
    end

    // State registers; reset drops any in-flight evaluation request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psr_q    <= '0;
            shadow_q <= '0;
            done_q   <= 1'b0;
            taken_q  <= 1'b0;
        end else begin
            psr_q    <= psr_d;
            shadow_q <= shadow_d;
            done_q   <= done_d;
            taken_q  <= taken_d;
        end
    end

    assign psr        = psr_q;
    assign carry_fb   = psr_q[C_BIT];
    assign shadow_psr = shadow_q;
    assign cond_done  = done_q;
    assign cond_taken = taken_q;

endmodule
